// File: rtl/bip_ctrl_pkg.sv
// Shared definitions for the BIP run controller and the instruction decoder:
// run-state encoding plus default opcode width and halt opcode.
package bip_ctrl_pkg;

  localparam int unsigned DEFAULT_OPCODE_W = 5;
  localparam logic [DEFAULT_OPCODE_W-1:0] DEFAULT_HLT_OPCODE = 5'b00000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CLEAR     = 3'd1,
    ST_RUN       = 3'd2,
    ST_WAIT_STEP = 3'd3,
    ST_EXEC      = 3'd4,
    ST_HALTED    = 3'd5
  } run_state_e;

endpackage

// File: rtl/bip_cycle_counter.sv
// Saturating executed-instruction counter with synchronous clear and a
// terminal-count compare used by the run controller's watchdog.
module bip_cycle_counter #(
  parameter int unsigned CNT_W    = 16,
  parameter bit          TERM_EN  = 1'b0,
  parameter int unsigned TERMINAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o,
  output logic             term_o
);

  localparam logic [CNT_W-1:0] TERM_VAL = CNT_W'(TERMINAL);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Clear wins over enable; the count sticks at all-ones instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign term_o  = TERM_EN ? (count_q == TERM_VAL) : 1'b0;

endmodule

// File: rtl/bip_run_controller.sv
// Run sequencer for the BIP accumulator core: launches a program, pulses the
// core reset, then gates execution free-running or one instruction per step.
module bip_run_controller
  import bip_ctrl_pkg::*;
#(
  parameter int unsigned          OPCODE_W   = DEFAULT_OPCODE_W,
  parameter int unsigned          CNT_W      = 16,
  parameter logic [OPCODE_W-1:0]  HLT_OPCODE = OPCODE_W'(DEFAULT_HLT_OPCODE),
  parameter int unsigned          MAX_CYCLES = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_start,
  input  logic                i_step_mode,
  input  logic                i_step,
  input  logic [OPCODE_W-1:0] i_opcode,
  output logic                o_core_rst,
  output logic                o_core_en,
  output logic                o_busy,
  output logic                o_halted,
  output logic                o_done,
  output logic                o_timeout,
  output logic [CNT_W-1:0]    o_cycles
);

  run_state_e state_q, state_d;
  logic       stepMode_q, stepMode_d;
  logic       timeout_q, timeout_d;
  logic       done_q, done_d;
  logic       isHlt;
  logic       cntTerm;
  logic       launch;

  assign isHlt  = (i_opcode == HLT_OPCODE);
  assign launch = ((state_q == ST_IDLE) || (state_q == ST_HALTED)) && i_start;

  bip_cycle_counter #(
    .CNT_W    (CNT_W),
    .TERM_EN  (MAX_CYCLES != 0),
    .TERMINAL ((MAX_CYCLES == 0) ? 0 : MAX_CYCLES - 1)
  ) u_counter (
    .clk     (clk),
    .reset   (reset),
    .clear_i (state_q == ST_CLEAR),
    .en_i    (o_core_en),
    .count_o (o_cycles),
    .term_o  (cntTerm)
  );

  // A HLT opcode suppresses the enable, so it always beats the watchdog.
  always_comb begin
    state_d    = state_q;
    o_core_en  = 1'b0;
    o_core_rst = 1'b0;
    o_busy     = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (i_start) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        o_core_rst = 1'b1;
        o_busy     = 1'b1;
        state_d    = stepMode_q ? ST_WAIT_STEP : ST_RUN;
      end
      ST_RUN: begin
        o_busy = 1'b1;
        if (isHlt) begin
          state_d = ST_HALTED;
        end else begin
          o_core_en = 1'b1;
          if (cntTerm) state_d = ST_HALTED;
        end
      end
      ST_WAIT_STEP: begin
        o_busy = 1'b1;
        if (isHlt) state_d = ST_HALTED;
        else if (i_step) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        o_busy = 1'b1;
        if (isHlt) begin
          state_d = ST_HALTED;
        end else begin
          o_core_en = 1'b1;
          state_d   = cntTerm ? ST_HALTED : ST_WAIT_STEP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    stepMode_d = launch ? i_step_mode : stepMode_q;
    timeout_d  = timeout_q;
    if (launch) timeout_d = 1'b0;
    else if (o_core_en && cntTerm) timeout_d = 1'b1;
    done_d = (state_d == ST_HALTED) && (state_q != ST_HALTED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      stepMode_q <= 1'b0;
      timeout_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      stepMode_q <= stepMode_d;
      timeout_q  <= timeout_d;
      done_q     <= done_d;
    end
  end

  assign o_halted  = (state_q == ST_HALTED);
  assign o_done    = done_q;
  assign o_timeout = timeout_q;

endmodule

// File: tb/tb_bip_run_controller.sv
// Self-checking bench for bip_run_controller: a cycle-level behavioural model
// compared every cycle, plus hand-computed checks per scenario.
module tb_bip_run_controller;

  localparam int CNT_W   = 16;
  localparam int MAX_CYC = 8;
  localparam logic [4:0] HLT = 5'b00000;

  logic             clk = 1'b0;
  logic             reset;
  logic             i_start, i_step_mode, i_step;
  logic [4:0]       i_opcode;
  logic             o_core_rst, o_core_en, o_busy, o_halted, o_done, o_timeout;
  logic [CNT_W-1:0] o_cycles;

  logic [4:0] prog [0:15];
  logic [3:0] pc;

  int testsRun    = 0;
  int testsFailed = 0;
  int enCnt, rstCnt, doneCnt;

  // Model state: whether a program is live, how far into it we are, and
  // whether a step pulse has granted the current cycle an execution.
  bit mValid = 1'b0;
  bit mBusy, mHalted, mTimeout, mDone, mStepMode, mGrant;
  bit mHlt, mEn, mWd;
  int mCount, mSince;

  bip_run_controller #(
    .OPCODE_W   (5),
    .CNT_W      (CNT_W),
    .HLT_OPCODE (HLT),
    .MAX_CYCLES (MAX_CYC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_start     (i_start),
    .i_step_mode (i_step_mode),
    .i_step      (i_step),
    .i_opcode    (i_opcode),
    .o_core_rst  (o_core_rst),
    .o_core_en   (o_core_en),
    .o_busy      (o_busy),
    .o_halted    (o_halted),
    .o_done      (o_done),
    .o_timeout   (o_timeout),
    .o_cycles    (o_cycles)
  );

  always #5 clk = ~clk;

  // Stand-in for the core's program counter and instruction memory.
  assign i_opcode = prog[pc];
  always @(posedge clk) begin
    if (reset || o_core_rst) pc <= '0;
    else if (o_core_en) pc <= pc + 4'd1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic bit expEn();
    return mBusy && (mSince >= 2) && (i_opcode != HLT) && (!mStepMode || mGrant);
  endfunction

  // Compare against the model mid-cycle, then advance the model with the
  // inputs that the coming rising edge will sample.
  initial begin
    forever begin
      @(negedge clk);
      if (mValid) begin
        checkOutput("core_rst", 32'(o_core_rst), 32'(mBusy && (mSince == 1)));
        checkOutput("core_en",  32'(o_core_en),  32'(expEn()));
        checkOutput("busy",     32'(o_busy),     32'(mBusy));
        checkOutput("halted",   32'(o_halted),   32'(mHalted));
        checkOutput("done",     32'(o_done),     32'(mDone));
        checkOutput("timeout",  32'(o_timeout),  32'(mTimeout));
        checkOutput("cycles",   32'(o_cycles),   32'(mCount));
      end
      if (o_core_en === 1'b1) enCnt++;
      if (o_core_rst === 1'b1) rstCnt++;
      if (o_done === 1'b1) doneCnt++;
      if (reset) begin
        {mBusy, mHalted, mTimeout, mDone, mStepMode, mGrant} = '0;
        mCount = 0;
        mSince = 0;
        mValid = 1'b1;
      end else if (mValid) begin
        mDone = 1'b0;
        if (!mBusy) begin
          if (i_start) begin
            mBusy     = 1'b1;
            mSince    = 1;
            mStepMode = i_step_mode;
            mHalted   = 1'b0;
            mTimeout  = 1'b0;
            mGrant    = 1'b0;
          end
        end else if (mSince == 1) begin
          mCount = 0;
          mSince = 2;
        end else begin
          mHlt = (i_opcode == HLT);
          mEn  = expEn();
          mWd  = mEn && (mCount == MAX_CYC - 1);
          if (mEn && mCount < 65535) mCount++;
          if (mHlt || mWd) begin
            mBusy    = 1'b0;
            mHalted  = 1'b1;
            mDone    = 1'b1;
            mTimeout = mWd;
            mGrant   = 1'b0;
          end else begin
            mGrant = mStepMode && !mGrant && i_step;
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk) #1;
  endtask

  // Holds the given pulses for exactly one rising edge.
  task automatic applyStimulus(input bit start, input bit mode, input bit step);
    @(posedge clk) #1;
    i_start     = start;
    i_step_mode = mode;
    i_step      = step;
    @(posedge clk) #1;
    i_start = 1'b0;
    i_step  = 1'b0;
  endtask

  task automatic waitHalted(input string name, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (o_halted) break;
      @(posedge clk) #1;
    end
    checkOutput(name, 32'(o_halted), 32'd1);
  endtask

  task automatic clearCounts();
    enCnt   = 0;
    rstCnt  = 0;
    doneCnt = 0;
  endtask

  initial begin
    reset       = 1'b1;
    i_start     = 1'b0;
    i_step_mode = 1'b0;
    i_step      = 1'b0;
    for (int i = 0; i < 16; i++) prog[i] = HLT;
    clearCounts();
    idle(3);
    checkOutput("rst_busy",   32'(o_busy),     32'd0);
    checkOutput("rst_halted", 32'(o_halted),   32'd0);
    checkOutput("rst_cycles", 32'(o_cycles),   32'd0);
    checkOutput("rst_en",     32'(o_core_en),  32'd0);
    checkOutput("rst_crst",   32'(o_core_rst), 32'd0);
    reset = 1'b0;
    idle(2);

    // Free run: LDI, ADDI, ADDI, STO, HLT
    prog[0] = 5'h09; prog[1] = 5'h0A; prog[2] = 5'h0A; prog[3] = 5'h0C; prog[4] = HLT;
    clearCounts();
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("free_crst", 32'(o_core_rst), 32'd1);
    waitHalted("free_halt", 30);
    checkOutput("free_done", 32'(o_done), 32'd1);
    idle(2);
    checkOutput("free_cycles",  32'(o_cycles), 32'd4);
    checkOutput("free_en_cnt",  32'(enCnt),    32'd4);
    checkOutput("free_rst_cnt", 32'(rstCnt),   32'd1);
    checkOutput("free_done_cnt", 32'(doneCnt), 32'd1);

    // Single-step: three instructions then HLT, plus a stray step after halt
    prog[0] = 5'h03; prog[1] = 5'h05; prog[2] = 5'h07; prog[3] = HLT;
    clearCounts();
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6 && !o_halted; i++) begin
      idle(4);
      applyStimulus(1'b0, 1'b0, 1'b1);
    end
    waitHalted("step_halt", 10);
    applyStimulus(1'b0, 1'b0, 1'b1);
    idle(2);
    checkOutput("step_cycles", 32'(o_cycles), 32'd3);
    checkOutput("step_en_cnt", 32'(enCnt),    32'd3);
    checkOutput("step_done_cnt", 32'(doneCnt), 32'd1);

    // Start and step pulses while running must not disturb the run
    for (int i = 0; i < 6; i++) prog[i] = 5'(i + 1);
    prog[6] = HLT;
    clearCounts();
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    waitHalted("ign_halt", 30);
    idle(2);
    checkOutput("ign_cycles",  32'(o_cycles), 32'd6);
    checkOutput("ign_rst_cnt", 32'(rstCnt),   32'd1);

    // Watchdog: program never reaches HLT
    for (int i = 0; i < 16; i++) prog[i] = 5'h11;
    clearCounts();
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitHalted("wd_halt", 40);
    checkOutput("wd_done", 32'(o_done), 32'd1);
    idle(2);
    checkOutput("wd_cycles",  32'(o_cycles),  32'd8);
    checkOutput("wd_timeout", 32'(o_timeout), 32'd1);
    checkOutput("wd_en_cnt",  32'(enCnt),     32'd8);

    // Restart on a program whose first opcode is HLT
    prog[0] = HLT;
    clearCounts();
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("h0_n1_crst",    32'(o_core_rst), 32'd1);
    checkOutput("h0_n1_timeout", 32'(o_timeout),  32'd0);
    checkOutput("h0_n1_halted",  32'(o_halted),   32'd0);
    idle(1);
    checkOutput("h0_n2_cycles", 32'(o_cycles), 32'd0);
    checkOutput("h0_n2_halted", 32'(o_halted), 32'd0);
    idle(1);
    checkOutput("h0_n3_halted", 32'(o_halted), 32'd1);
    checkOutput("h0_n3_done",   32'(o_done),   32'd1);
    idle(2);
    checkOutput("h0_en_cnt", 32'(enCnt), 32'd0);

    // Reset in the middle of a free run with five instructions executed
    prog[0] = 5'h11;
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (o_cycles == 16'd4) break;
      @(posedge clk) #1;
    end
    @(posedge clk) #1;
    reset = 1'b1;
    checkOutput("mid_cycles5", 32'(o_cycles), 32'd5);
    @(posedge clk) #1;
    checkOutput("mid_busy",   32'(o_busy),     32'd0);
    checkOutput("mid_cycles", 32'(o_cycles),   32'd0);
    checkOutput("mid_en",     32'(o_core_en),  32'd0);
    checkOutput("mid_halted", 32'(o_halted),   32'd0);
    reset = 1'b0;
    idle(3);
    checkOutput("mid_idle_busy", 32'(o_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
